serial_logic_unit: RTL and testbench
====================================

# serial_logic_unit

Parametrised successor to the 4-bit lab processor: a WIDTH-bit, two-register bit-serial logic unit. Operands are loaded from switches into registers A and B. A single Execute press streams both registers through a serial logic cell for exactly WIDTH cycles, applying function F and routing mode R. Sits between the debounced board buttons/switches and the hex/LED display logic, with Busy/Done status added for a future controller.

## Interface
- WIDTH, 8, register and data-path width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), shift-counter width (derived, do not override).

- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- LoadA  in  1  level; load Din into A.
- LoadB  in  1  level; load Din into B.
- Execute  in  1  level; start one computation per assertion.
- Din  in  WIDTH  load data.
- F  in  3  function select, latched at start of execute.
- R  in  2  routing select, latched at start of execute.
- Aval  out  WIDTH  register A contents.
- Bval  out  WIDTH  register B contents.
- Busy  out  1  high while shifting.
- Done  out  1  one-cycle pulse after the final shift.

## Operation
- Reset (Reset=0, asynchronous): A=0, B=0, Busy=0, Done=0, counter=0, latched F/R=0, state=IDLE. A computation in progress is abandoned with no partial writeback guarantee; after release the registers read 0.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - Execute=1: latch F and R, counter=0, go to SHIFT. Execute has priority: LoadA/LoadB in the same cycle are ignored.
  - Otherwise LoadA=1 sets A=Din, and LoadB=1 sets B=Din. Both asserted loads both.
- SHIFT, each cycle:
  - f = F_lut(A[0], B[0]).
  - A and B both shift right by one.
  - New MSBs per latched R: 00 A←A[0], B←B[0] (rotate, no change); 01 A←A[0], B←f; 10 A←f, B←B[0]; 11 A←B[0], B←A[0] (swap).
  - Counter increments. The cycle with counter==WIDTH-1 is the last shift and moves to HOLD.
  - Loads are ignored. Changes on F and R are ignored.
- F_lut: 000 AND, 001 OR, 010 XOR, 011 constant 1, 100 NAND, 101 NOR, 110 XNOR, 111 constant 0.
- HOLD: stay until Execute=0, then go to IDLE. Loads are ignored. A held Execute never re-triggers.
- Done is registered and asserted on the SHIFT→HOLD transition only.

## Timing
- Execute first seen high at edge k (state IDLE): SHIFT entered at k. Shifts occur at edges k+1 … k+WIDTH.
- Aval/Bval hold the final result after edge k+WIDTH. Done=1 for exactly the cycle following edge k+WIDTH.
- Busy=1 from after edge k through edge k+WIDTH (WIDTH cycles).
- Load latency: Din appears on Aval/Bval one edge after LoadA/LoadB is sampled in IDLE.
- Minimum spacing between computations: WIDTH+2 edges, since Execute must be sampled low in HOLD.
- Aval/Bval change during SHIFT (intermediate rotated values). Consumers use Done or !Busy.

## Configuration
- SERIAL_LOGIC_UNIT_SYNC_EN:
  - Defined: LoadA, LoadB and Execute each pass through a 2-flop synchroniser (reset to 0) before the FSM. All input-to-state latencies above grow by 2 cycles. Din, F and R are not synchronised; they must be stable 2 cycles before and during sampling.
  - Undefined: the inputs drive the FSM directly and must already be synchronous to Clk.

## Test plan
- Reset and load: hold Reset=0 for 3 edges → Aval=Bval=0, Busy=Done=0. Then LoadA with Din=8'hB5 → Aval=8'hB5; LoadB with Din=8'h2C → Bval=8'h2C.
- XOR into A, WIDTH=8: A=8'hB5, B=8'h2C, F=010, R=10, Execute held 12 cycles → Done pulses once, 8 edges after start; Aval=8'h99, Bval=8'h2C; no second Done while Execute is held.
- XNOR into B: from the above, F=110, R=01, Execute pulse; change F to 000 mid-shift → Aval=8'h99, Bval=8'h4A (F latched at start).
- Swap with WIDTH=4 regression: A=4'h9, B=4'hD, R=11 → Aval=4'hD, Bval=4'h9. Also rerun the 4-bit sequence B^2 → A=9, then XNOR → B=4, then swap → A=4, B=9.
- Priority and ignores: Execute and LoadA in the same IDLE cycle with Din=8'hFF → A not loaded. LoadB asserted during SHIFT and HOLD → Bval is the computed value only.
- Reset mid-shift: assert Reset=0 at shift 3 → Aval=Bval=0, Busy=0 immediately (asynchronous), no Done. After release, state is IDLE and accepts a new load.

Source files
------------

// File: rtl/serial_logic_unit.sv
// WIDTH-bit two-register bit-serial logic unit: load A/B, then stream both through a LUT cell.
// Optional SERIAL_LOGIC_UNIT_SYNC_EN adds 2-flop synchronisers on LoadA/LoadB/Execute.
module serial_logic_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LoadA,
   input  logic             LoadB,
   input  logic             Execute,
   input  logic [WIDTH-1:0] Din,
   input  logic [2:0]       F,
   input  logic [1:0]       R,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       f_q, f_d;
   logic [1:0]       r_q, r_d;
   logic             done_q, done_d;
   logic             load_a, load_b, execute;
   logic             bit_f, msb_a, msb_b;

`ifdef SERIAL_LOGIC_UNIT_SYNC_EN
   logic [1:0] la_sync_q, la_sync_d, lb_sync_q, lb_sync_d, ex_sync_q, ex_sync_d;

   always_comb begin
      la_sync_d = {la_sync_q[0], LoadA};
      lb_sync_d = {lb_sync_q[0], LoadB};
      ex_sync_d = {ex_sync_q[0], Execute};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         la_sync_q <= '0;
         lb_sync_q <= '0;
         ex_sync_q <= '0;
      end else begin
         la_sync_q <= la_sync_d;
         lb_sync_q <= lb_sync_d;
         ex_sync_q <= ex_sync_d;
      end
   end

   assign load_a  = la_sync_q[1];
   assign load_b  = lb_sync_q[1];
   assign execute = ex_sync_q[1];
`else
   assign load_a  = LoadA;
   assign load_b  = LoadB;
   assign execute = Execute;
`endif

   // Upper select bit inverts the basic AND/OR/XOR/ONE result.
   function automatic logic f_lut(input logic [2:0] sel, input logic a, input logic b);
      logic y;
      case (sel[1:0])
         2'b00:   y = a & b;
         2'b01:   y = a | b;
         2'b10:   y = a ^ b;
         default: y = 1'b1;
      endcase
      return sel[2] ? ~y : y;
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      f_d     = f_q;
      r_d     = r_q;
      done_d  = 1'b0;
      bit_f   = f_lut(f_q, a_q[0], b_q[0]);
      msb_a   = a_q[0];
      msb_b   = b_q[0];
      case (state_q)
         IDLE: begin
            if (execute) begin
               f_d     = F;
               r_d     = R;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               if (load_a) a_d = Din;
               if (load_b) b_d = Din;
            end
         end
         SHIFT: begin
            case (r_q)
               2'b01: msb_b = bit_f;
               2'b10: msb_a = bit_f;
               2'b11: begin
                  msb_a = b_q[0];
                  msb_b = a_q[0];
               end
               default: ;
            endcase
            a_d   = {msb_a, a_q[WIDTH-1:1]};
            b_d   = {msb_b, b_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = HOLD;
               done_d  = 1'b1;
            end
         end
         HOLD: begin
            // Wait for Execute release so a held button runs only once.
            if (!execute) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         f_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         f_q     <= f_d;
         r_q     <= r_d;
         done_q  <= done_d;
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign Busy = (state_q == SHIFT);
   assign Done = done_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: transaction-level reference model checked every cycle,
// directed literal cases (8-bit and 4-bit instances) and randomized traffic.
module tb_serial_logic_unit;
   localparam int W = 8;

   logic         Clk = 1'b0, Reset = 1'b0, LoadA = 1'b0, LoadB = 1'b0, Execute = 1'b0;
   logic [W-1:0] Din = '0;
   logic [2:0]   F = '0;
   logic [1:0]   R = '0;
   logic [W-1:0] Aval, Bval;
   logic         Busy, Done;

   logic       la4 = 1'b0, lb4 = 1'b0, ex4 = 1'b0;
   logic [3:0] din4 = '0;
   logic [2:0] f4 = '0;
   logic [1:0] r4 = '0;
   logic [3:0] a4, b4;
   logic       busy4, done4;

   int total = 0, bad = 0, done_cnt = 0;

   serial_logic_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
      .Din(Din), .F(F), .R(R), .Aval(Aval), .Bval(Bval), .Busy(Busy), .Done(Done)
   );

   serial_logic_unit #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .LoadA(la4), .LoadB(lb4), .Execute(ex4),
      .Din(din4), .F(f4), .R(r4), .Aval(a4), .Bval(b4), .Busy(busy4), .Done(done4)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-word meaning of the serial computation: WIDTH shifts apply the LUT bitwise.
   function automatic logic [W-1:0] lut(input logic [2:0] f, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      case (f)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return '1;
         3'd4: return ~(a & b);
         3'd5: return ~(a | b);
         3'd6: return ~(a ^ b);
         default: return '0;
      endcase
   endfunction

   // Reference model: phase 0 = ready, 1 = computing, 2 = waiting for Execute release.
   int           m_phase = 0, m_left = 0;
   logic [W-1:0] m_a = '0, m_b = '0, m_t;
   logic [2:0]   m_f = '0;
   logic [1:0]   m_r = '0;
   logic         m_done = 1'b0;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_phase = 0; m_left = 0; m_a = '0; m_b = '0; m_f = '0; m_r = '0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_phase == 0) begin
            if (Execute) begin
               m_f = F; m_r = R; m_left = W; m_phase = 1;
            end else begin
               if (LoadA) m_a = Din;
               if (LoadB) m_b = Din;
            end
         end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
               case (m_r)
                  2'd1: m_b = lut(m_f, m_a, m_b);
                  2'd2: m_a = lut(m_f, m_a, m_b);
                  2'd3: begin m_t = m_a; m_a = m_b; m_b = m_t; end
                  default: ;
               endcase
               m_done = 1'b1;
               m_phase = 2;
            end
         end else if (!Execute) begin
            m_phase = 0;
         end
      end
   end

   always @(negedge Clk) begin
      chk("busy", 32'(Busy), 32'(m_phase == 1));
      chk("done", 32'(Done), 32'(m_done));
      if (Done) done_cnt++;
      if (m_phase != 1) begin
         chk("aval", 32'(Aval), 32'(m_a));
         chk("bval", 32'(Bval), 32'(m_b));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (Busy && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk({name, "_timeout"}, 32'(n < 100), 32'd1);
   endtask

   task automatic load(input logic a, input logic b, input logic [W-1:0] d);
      LoadA = a; LoadB = b; Din = d;
      cyc(1);
      LoadA = 1'b0; LoadB = 1'b0;
   endtask

   task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] f, input logic [1:0] r,
                       input logic [3:0] ea, input logic [3:0] eb);
      din4 = a; la4 = 1'b1; cyc(1); la4 = 1'b0;
      din4 = b; lb4 = 1'b1; cyc(1); lb4 = 1'b0;
      f4 = f; r4 = r; ex4 = 1'b1; cyc(1); ex4 = 1'b0;
      cyc(6);
      chk({name, "_a"}, 32'(a4), 32'(ea));
      chk({name, "_b"}, 32'(b4), 32'(eb));
      $display("txn w4 %s f=%0d r=%0d -> a=%h b=%h", name, f, r, a4, b4);
   endtask

   initial begin
      int d0, pos, hold;
      cyc(3);
      chk("rst_a", 32'(Aval), 32'h0);
      chk("rst_b", 32'(Bval), 32'h0);
      chk("rst_busy", 32'(Busy), 32'h0);
      chk("rst_done", 32'(Done), 32'h0);
      Reset = 1'b1;
      cyc(1);

      load(1'b1, 1'b0, 8'hB5);
      chk("load_a", 32'(Aval), 32'hB5);
      load(1'b0, 1'b1, 8'h2C);
      chk("load_b", 32'(Bval), 32'h2C);
      $display("txn load a=%h b=%h", Aval, Bval);

      // XOR into A, Execute held well past completion.
      d0 = done_cnt; pos = 0;
      F = 3'b010; R = 2'b10; Execute = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (Done) pos = i;
      end
      Execute = 1'b0;
      cyc(2);
      chk("xor_a", 32'(Aval), 32'h99);
      chk("xor_b", 32'(Bval), 32'h2C);
      chk("xor_done_once", 32'(done_cnt - d0), 32'd1);
      chk("xor_done_pos", 32'(pos), 32'd9);
      $display("txn xor a=%h b=%h", Aval, Bval);

      // XNOR into B with F changed mid-computation.
      F = 3'b110; R = 2'b01; Execute = 1'b1;
      cyc(1); Execute = 1'b0;
      cyc(2); F = 3'b000; R = 2'b00;
      wait_idle("xnor");
      cyc(1);
      chk("xnor_a", 32'(Aval), 32'h99);
      chk("xnor_b", 32'(Bval), 32'h4A);
      $display("txn xnor a=%h b=%h", Aval, Bval);

      // Execute wins over LoadA; LoadB ignored while computing and holding.
      Execute = 1'b1; LoadA = 1'b1; Din = 8'hFF; F = 3'b011; R = 2'b01;
      cyc(1);
      LoadA = 1'b0; LoadB = 1'b1; Din = 8'h00;
      cyc(12);
      Execute = 1'b0; LoadB = 1'b0;
      cyc(2);
      chk("prio_a", 32'(Aval), 32'h99);
      chk("prio_b", 32'(Bval), 32'hFF);
      $display("txn prio a=%h b=%h", Aval, Bval);

      // Asynchronous reset in the middle of a computation.
      d0 = done_cnt;
      F = 3'b000; R = 2'b10; Execute = 1'b1;
      cyc(1); Execute = 1'b0;
      repeat (3) @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("amid_busy", 32'(Busy), 32'h0);
      chk("amid_a", 32'(Aval), 32'h0);
      chk("amid_b", 32'(Bval), 32'h0);
      cyc(2);
      Reset = 1'b1;
      cyc(12);
      chk("amid_no_done", 32'(done_cnt - d0), 32'd0);
      load(1'b1, 1'b0, 8'h5A);
      chk("amid_load", 32'(Aval), 32'h5A);
      $display("txn reset-mid a=%h b=%h", Aval, Bval);

      // 4-bit instance regressions.
      run4("swap4", 4'h9, 4'hD, 3'b000, 2'b11, 4'hD, 4'h9);
      run4("xor4", 4'hB, 4'h2, 3'b010, 2'b10, 4'h9, 4'h2);
      f4 = 3'b110; r4 = 2'b01; ex4 = 1'b1; cyc(1); ex4 = 1'b0; cyc(6);
      chk("xnor4_b", 32'(b4), 32'h4);
      f4 = 3'b000; r4 = 2'b11; ex4 = 1'b1; cyc(1); ex4 = 1'b0; cyc(6);
      chk("swap4b_a", 32'(a4), 32'h4);
      chk("swap4b_b", 32'(b4), 32'h9);
      $display("txn w4 chain a=%h b=%h", a4, b4);

      // Randomized traffic; the per-cycle checker carries the comparisons.
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            load(1'($urandom), 1'($urandom), W'($urandom));
         end
         F = 3'($urandom); R = 2'($urandom);
         LoadA = 1'($urandom); LoadB = 1'($urandom); Din = W'($urandom);
         Execute = 1'b1;
         hold = int'($urandom_range(1, W + 5));
         for (int i = 0; i < hold; i++) begin
            cyc(1);
            LoadA = 1'($urandom); LoadB = 1'($urandom); Din = W'($urandom);
            F = 3'($urandom); R = 2'($urandom);
         end
         Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
         wait_idle("rand");
         cyc(2);
         $display("txn rand %0d a=%h b=%h", t, Aval, Bval);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
